// File: rtl/worm_move_sequencer.sv
// rtl/worm_move_sequencer.sv - queued move commands stepped across a 16x16 grid
//
// worm_cmd_queue: circular command FIFO
//   s_tdata/s_tvalid        push side; a push while full is dropped unless a pop lands on the same edge
//   m_tdata/m_tvalid/m_tready pop side; m_tvalid means non-empty
//   count                   queued entries
//   drop                    combinational: the push on this edge is being dropped
//
// worm_move_sequencer: top
//   clk, rst                clock, synchronous active-high reset
//   inp[1:0]                direction: 00 x-1, 01 x+1, 10 y+1, 11 y-1
//   inp[3:2]                distance 0..3
//   rotation_event          a push is taken on its rising edge
//   x_coordinate            worm x, 0..15
//   y_coordinate            worm y, 0..15
//   busy                    moving, or commands still queued
//   fifo_count              queued commands
//   overflow                sticky: a command was dropped
//   wall_hit                one-cycle pulse: a step was blocked by a wall
//   move_done               one-cycle pulse: a command finished

module worm_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        s_tdata,
    input  logic                    s_tvalid,
    output logic [WIDTH-1:0]        m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == FULL_COUNT);
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign do_pop   = m_tvalid && m_tready;
    // A pop on the same edge frees the slot the push needs; when full the
    // write lands on the entry being read out, which is already on m_tdata.
    assign do_push  = s_tvalid && (!full || do_pop);
    assign drop     = s_tvalid && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module worm_move_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   inp,
    input  logic                         rotation_event,
    output logic [3:0]                   x_coordinate,
    output logic [3:0]                   y_coordinate,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         wall_hit,
    output logic                         move_done
);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(STEP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic           prev_rot;
    logic           push;
    logic           pop;
    logic           drop;
    logic [3:0]     q_tdata;
    logic           q_tvalid;
    logic [1:0]     cmd_dir;
    logic [1:0]     cmd_dir_n;
    logic [1:0]     remaining;
    logic [1:0]     remaining_n;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_n;
    logic [3:0]     x_n;
    logic [3:0]     y_n;
    logic           wall_hit_n;
    logic           move_done_n;

    assign push = rotation_event && !prev_rot;
    assign busy = (state != IDLE) || (fifo_count != '0);

    worm_cmd_queue #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (inp),
        .s_tvalid (push),
        .m_tdata  (q_tdata),
        .m_tvalid (q_tvalid),
        .m_tready (pop),
        .count    (fifo_count),
        .drop     (drop)
    );

    always_comb begin
        state_n     = state;
        cmd_dir_n   = cmd_dir;
        remaining_n = remaining;
        timer_n     = timer;
        x_n         = x_coordinate;
        y_n         = y_coordinate;
        wall_hit_n  = 1'b0;
        move_done_n = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (q_tvalid) begin
                    pop         = 1'b1;
                    cmd_dir_n   = q_tdata[1:0];
                    remaining_n = q_tdata[3:2];
                    if (q_tdata[3:2] == 2'd0) begin
                        move_done_n = 1'b1;
                    end else begin
                        timer_n = TIMER_RELOAD;
                        state_n = MOVE;
                    end
                end
            end
            MOVE: begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else begin
                    // Saturation is tested before the update, so a blocked
                    // step still spends one unit of distance.
                    case (cmd_dir)
                        2'b00: if (x_coordinate == 4'd0)  wall_hit_n = 1'b1; else x_n = x_coordinate - 1'b1;
                        2'b01: if (x_coordinate == 4'd15) wall_hit_n = 1'b1; else x_n = x_coordinate + 1'b1;
                        2'b10: if (y_coordinate == 4'd15) wall_hit_n = 1'b1; else y_n = y_coordinate + 1'b1;
                        2'b11: if (y_coordinate == 4'd0)  wall_hit_n = 1'b1; else y_n = y_coordinate - 1'b1;
                        default: ;
                    endcase
                    remaining_n = remaining - 1'b1;
                    if (remaining == 2'd1) begin
                        move_done_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        timer_n = TIMER_RELOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev_rot     <= 1'b0;
            cmd_dir      <= 2'd0;
            remaining    <= 2'd0;
            timer        <= '0;
            x_coordinate <= 4'd0;
            y_coordinate <= 4'd0;
            overflow     <= 1'b0;
            wall_hit     <= 1'b0;
            move_done    <= 1'b0;
        end else begin
            state        <= state_n;
            prev_rot     <= rotation_event;
            cmd_dir      <= cmd_dir_n;
            remaining    <= remaining_n;
            timer        <= timer_n;
            x_coordinate <= x_n;
            y_coordinate <= y_n;
            overflow     <= overflow | drop;
            wall_hit     <= wall_hit_n;
            move_done    <= move_done_n;
        end
    end
endmodule

// File: tb/tb_worm_move_sequencer.sv
// tb/tb_worm_move_sequencer.sv - directed vector bench for worm_move_sequencer

module tb_worm_move_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] inp;
    logic       rotation_event;
    logic [3:0] x_coordinate;
    logic [3:0] y_coordinate;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       wall_hit;
    logic       move_done;

    worm_move_sequencer #(
        .FIFO_DEPTH  (4),
        .STEP_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inp            (inp),
        .rotation_event (rotation_event),
        .x_coordinate   (x_coordinate),
        .y_coordinate   (y_coordinate),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .wall_hit       (wall_hit),
        .move_done      (move_done)
    );

    always #5 clk = ~clk;

    int cyc       = 0;
    int done_cnt  = 0;
    int wall_cnt  = 0;
    int done_cyc  = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int push_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (move_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (wall_hit === 1'b1) begin
            wall_cnt <= wall_cnt + 1;
        end
    end

    typedef struct {
        logic [3:0] cmd;
        int         exp_x;
        int         exp_y;
        int         exp_walls;
        int         exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rotation_event = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge after the push edge E.
    task automatic push(input logic [3:0] c);
        inp = c;
        rotation_event = 1'b1;
        @(negedge clk);
        rotation_event = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic wait_idle(input int target, input string name);
        int n;
        n = 0;
        #1;
        while (!(done_cnt >= target && busy == 1'b0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({"idle_timeout_", name}, int'(n < 300), 1);
    endtask

    initial begin
        int base_done;
        int base_wall;
        int maxc;
        int exp_x;

        vecs[0]  = '{4'b1101, 3,  0, 0, 13};
        vecs[1]  = '{4'b1110, 3,  3, 0, 13};
        vecs[2]  = '{4'b0100, 2,  3, 0, 5};
        vecs[3]  = '{4'b1111, 2,  0, 0, 13};
        vecs[4]  = '{4'b1011, 2,  0, 2, 9};
        vecs[5]  = '{4'b1100, 0,  0, 1, 13};
        vecs[6]  = '{4'b0001, 0,  0, 0, 1};
        vecs[7]  = '{4'b1010, 0,  2, 0, 9};
        vecs[8]  = '{4'b1110, 0,  5, 0, 13};
        vecs[9]  = '{4'b1110, 0,  8, 0, 13};
        vecs[10] = '{4'b1110, 0, 11, 0, 13};
        vecs[11] = '{4'b1110, 0, 14, 0, 13};
        vecs[12] = '{4'b1110, 0, 15, 2, 13};
        vecs[13] = '{4'b1101, 3, 15, 0, 13};
        vecs[14] = '{4'b0111, 3, 14, 0, 5};

        rst = 1'b1;
        inp = 4'd0;
        rotation_event = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_x", int'(x_coordinate), 0);
        check("rst_y", int'(y_coordinate), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_wall_hit", int'(wall_hit), 0);
        check("rst_move_done", int'(move_done), 0);

        // Table: commands run back to back from the origin.
        for (int i = 0; i < 15; i++) begin
            base_done = done_cnt;
            base_wall = wall_cnt;
            push(vecs[i].cmd);
            wait_idle(base_done + 1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_x", i), int'(x_coordinate), vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), int'(y_coordinate), vecs[i].exp_y);
            check($sformatf("vec%0d_walls", i), wall_cnt - base_wall, vecs[i].exp_walls);
            check($sformatf("vec%0d_done", i), done_cnt - base_done, 1);
            check($sformatf("vec%0d_latency", i), done_cyc - push_cyc, vecs[i].exp_lat);
        end
        check("tbl_overflow", int'(overflow), 0);

        // Single move: per-cycle trace after push edge E (k = cycles after E).
        do_reset();
        push(4'b1101);
        for (int k = 0; k <= 16; k++) begin
            exp_x = (k >= 13) ? 3 : (k >= 9) ? 2 : (k >= 5) ? 1 : 0;
            check($sformatf("single_x_k%0d", k), int'(x_coordinate), exp_x);
            check($sformatf("single_y_k%0d", k), int'(y_coordinate), 0);
            check($sformatf("single_busy_k%0d", k), int'(busy), (k < 13) ? 1 : 0);
            check($sformatf("single_done_k%0d", k), int'(move_done), (k == 13) ? 1 : 0);
            @(negedge clk);
        end

        // Wall saturation at x=0: pulses after E+5 and E+9.
        do_reset();
        base_done = done_cnt;
        push(4'b1000);
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("wall_pulse_k%0d", k), int'(wall_hit), (k == 5 || k == 9) ? 1 : 0);
            check($sformatf("wall_x_k%0d", k), int'(x_coordinate), 0);
            @(negedge clk);
        end
        wait_idle(base_done + 1, "wall");
        check("wall_done_count", done_cnt - base_done, 1);

        // Zero distance: done after E+1 without entering MOVE.
        do_reset();
        push(4'b0010);
        check("zero_busy_k0", int'(busy), 1);
        @(negedge clk);
        check("zero_done_k1", int'(move_done), 1);
        check("zero_busy_k1", int'(busy), 0);
        check("zero_y", int'(y_coordinate), 0);

        // Overflow: six pushes two cycles apart, the last one dropped.
        do_reset();
        base_done = done_cnt;
        push(4'b1101);
        @(negedge clk); push(4'b0110);
        @(negedge clk); push(4'b1001);
        @(negedge clk); push(4'b0110);
        @(negedge clk); push(4'b0100);
        check("ovf_before_drop", int'(overflow), 0);
        @(negedge clk); push(4'b1110);
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_flag", int'(overflow), 1);
        wait_idle(base_done + 5, "ovf");
        check("ovf_done_count", done_cnt - base_done, 5);
        check("ovf_final_x", int'(x_coordinate), 4);
        check("ovf_final_y", int'(y_coordinate), 2);
        check("ovf_sticky", int'(overflow), 1);
        do_reset();
        check("ovf_cleared", int'(overflow), 0);

        // Level hold: one push only.
        base_done = done_cnt;
        inp = 4'b0101;
        rotation_event = 1'b1;
        maxc = 0;
        repeat (20) begin
            @(negedge clk);
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        rotation_event = 1'b0;
        wait_idle(base_done + 1, "hold");
        check("hold_max_count", maxc, 1);
        check("hold_done_count", done_cnt - base_done, 1);
        check("hold_x", int'(x_coordinate), 1);

        // Reset on the second step edge of a distance-3 move with 2 queued.
        do_reset();
        push(4'b1101);
        @(negedge clk); push(4'b0110);
        @(negedge clk); push(4'b0110);
        repeat (4) @(negedge clk);
        check("rmid_x_before", int'(x_coordinate), 1);
        check("rmid_count_before", int'(fifo_count), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_x", int'(x_coordinate), 0);
        check("rmid_y", int'(y_coordinate), 0);
        check("rmid_count", int'(fifo_count), 0);
        check("rmid_busy", int'(busy), 0);
        #1;
        base_done = done_cnt;
        base_wall = wall_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("rmid_x_after", int'(x_coordinate), 0);
        check("rmid_y_after", int'(y_coordinate), 0);
        check("rmid_no_done", done_cnt - base_done, 0);
        check("rmid_no_wall", wall_cnt - base_wall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
